// File: rtl/spi_slave_shift_frame.sv
// SPI slave shift engine: oversampled pins, configurable mode and bit order,
// back-to-back frames inside one ss window and a mid-frame release error pulse.
module spi_slave_shift_frame #(
    parameter int          WIDTH     = 8,
    parameter int          CPOL      = 0,
    parameter int          CPHA      = 0,
    parameter int          MSB_FIRST = 1,
    parameter logic [31:0] RST_RX    = 32'h7E
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         ss,
    input  logic                         din,
    input  logic [WIDTH-1:0]             tx_data,
    output logic                         miso,
    output logic                         miso_oe,
    output logic [WIDTH-1:0]             rx_data,
    output logic                         rx_valid,
    output logic                         busy,
    output logic                         frame_err,
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  FULL     = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] RX_INIT = RST_RX[WIDTH-1:0];
    localparam logic           IDLE_LVL = CPOL[0];

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       sclk_q, ss_q;
    logic [1:0]       din_q;
    logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             shifted_q, shifted_d;

    logic lead, trail, sample_edge, shift_edge, ss_fall, ss_rise, done;

    // Index 1 is the synchronised level, index 2 its one-clk-old copy for edges.
    assign lead        = (sclk_q[1] != IDLE_LVL) && (sclk_q[2] == IDLE_LVL);
    assign trail       = (sclk_q[1] == IDLE_LVL) && (sclk_q[2] != IDLE_LVL);
    assign sample_edge = (CPHA != 0) ? trail : lead;
    assign shift_edge  = (CPHA != 0) ? lead : trail;
    assign ss_fall     = !ss_q[1] && ss_q[2];
    assign ss_rise     = ss_q[1] && !ss_q[2];
    assign done        = (bit_cnt_q == FULL);

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        bit_cnt_d   = bit_cnt_q;
        shifted_d   = shifted_q;

        // A full count completes the frame one clk after the last sample, in either state.
        if (done) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
        end

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d    = ACTIVE;
                    tx_shift_d = tx_data;
                    bit_cnt_d  = '0;
                    shifted_d  = 1'b0;
                end
            end
            ACTIVE: begin
                if (sample_edge) begin
                    rx_shift_d = (MSB_FIRST != 0) ? {rx_shift_q[WIDTH-2:0], din_q[1]}
                                                  : {din_q[1], rx_shift_q[WIDTH-1:1]};
                    bit_cnt_d  = bit_cnt_d + CNT_ONE;
                end
                // The first shift edge of a frame only holds the first bit on miso.
                if (done) begin
                    tx_shift_d = tx_data;
                    shifted_d  = 1'b0;
                end else if (shift_edge && (bit_cnt_q != '0 || shifted_q)) begin
                    tx_shift_d = (MSB_FIRST != 0) ? {tx_shift_q[WIDTH-2:0], 1'b0}
                                                  : {1'b0, tx_shift_q[WIDTH-1:1]};
                    shifted_d  = 1'b1;
                end
                if (ss_rise) begin
                    state_d     = IDLE;
                    frame_err_d = (bit_cnt_d != '0) && (bit_cnt_d != FULL);
                    if (bit_cnt_d != FULL) bit_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q      <= {3{IDLE_LVL}};
            ss_q        <= 3'b111;
            din_q       <= 2'b00;
            state_q     <= IDLE;
            rx_shift_q  <= RX_INIT;
            tx_shift_q  <= '0;
            rx_data_q   <= RX_INIT;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            bit_cnt_q   <= '0;
            shifted_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, as in hardware.
            sclk_q      <= {sclk_q[1:0], sclk};
            ss_q        <= {ss_q[1:0], ss};
            din_q       <= {din_q[0], din};
            state_q     <= state_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            bit_cnt_q   <= bit_cnt_d;
            shifted_q   <= shifted_d;
        end
    end

    assign miso      = (MSB_FIRST != 0) ? tx_shift_q[WIDTH-1] : tx_shift_q[0];
    assign miso_oe   = ~ss_q[1];
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = (state_q == ACTIVE);
    assign frame_err = frame_err_q;
    assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_spi_slave_shift_frame.sv
// Bench for spi_slave_shift_frame: a mode-0 MSB-first 8-bit slave and a mode-3
// LSB-first 16-bit slave, driven by behavioural SPI masters.
`timescale 1ns/1ps
module tb_spi_slave_shift_frame;

    localparam int H = 8;  // sclk half period in clk cycles

    logic        clk = 1'b0;
    logic        rst_n;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;

    logic        sclk_a, ss_a, din_a, miso_a, miso_oe_a, rx_valid_a, busy_a, frame_err_a;
    logic [7:0]  tx_a, rx_data_a;
    logic [3:0]  bit_cnt_a;

    logic        sclk_b, ss_b, din_b, miso_b, miso_oe_b, rx_valid_b, busy_b, frame_err_b;
    logic [15:0] tx_b, rx_data_b;
    logic [4:0]  bit_cnt_b;

    spi_slave_shift_frame u_mode0 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk_a), .ss(ss_a), .din(din_a), .tx_data(tx_a),
        .miso(miso_a), .miso_oe(miso_oe_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .busy(busy_a), .frame_err(frame_err_a), .bit_cnt(bit_cnt_a)
    );

    spi_slave_shift_frame #(.WIDTH(16), .CPOL(1), .CPHA(1), .MSB_FIRST(0)) u_mode3 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk_b), .ss(ss_b), .din(din_b), .tx_data(tx_b),
        .miso(miso_b), .miso_oe(miso_oe_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .busy(busy_b), .frame_err(frame_err_b), .bit_cnt(bit_cnt_b)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor
    int          nvalid_a = 0, nerr_a = 0, dbl_a = 0, valid_cyc_a = 0;
    int          nvalid_b = 0, nerr_b = 0, dbl_b = 0;
    logic        prev_a = 1'b0, prev_b = 1'b0;
    logic [15:0] rxq_b[$];

    always @(negedge clk) begin
        if (rx_valid_a) begin
            nvalid_a++;
            valid_cyc_a = cyc;
            if (prev_a) dbl_a++;
        end
        if (rx_valid_b) begin
            nvalid_b++;
            rxq_b.push_back(rx_data_b);
            if (prev_b) dbl_b++;
        end
        if (frame_err_a) nerr_a++;
        if (frame_err_b) nerr_b++;
        prev_a = rx_valid_a;
        prev_b = rx_valid_b;
    end

    logic [7:0] exp_rx_a = 8'h7E;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode-0 master: rel 0 keeps ss low, 1 releases after the frame,
    // 2 releases together with the last sampling edge.
    task automatic xfer_a(input logic [7:0] mosi, input logic [7:0] tx, input logic [7:0] nxt,
                          input int nbits, input int rel, output logic [7:0] seen,
                          output int lead_cyc);
        seen     = '0;
        lead_cyc = 0;
        tx_a     = tx;
        ss_a     = 1'b0;
        wait_clk(H);
        for (int i = 0; i < nbits; i++) begin
            din_a = mosi[7-i];
            wait_clk(H);
            seen[7-i] = miso_a;
            sclk_a    = 1'b1;
            lead_cyc  = cyc;
            if (i == 0) tx_a = nxt;
            if (rel == 2 && i == nbits - 1) ss_a = 1'b1;
            wait_clk(H);
            sclk_a = 1'b0;
        end
        wait_clk(H);
        if (rel == 1) begin
            ss_a = 1'b1;
            wait_clk(H);
        end
    endtask

    // Mode-3 LSB-first master for one 16-bit frame; ss is handled by the caller.
    task automatic xfer_b(input logic [15:0] mosi, input logic [15:0] nxt, output logic [15:0] seen);
        seen = '0;
        for (int i = 0; i < 16; i++) begin
            sclk_b = 1'b0;
            din_b  = mosi[i];
            if (i == 0) tx_b = nxt;
            wait_clk(H);
            seen[i] = miso_b;
            sclk_b  = 1'b1;
            wait_clk(H);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_clk(3);
        n_checks++; if (rx_data_a !== 8'h7E) begin n_fail++; $display("FAIL reset_rx_data_a: got %h want 7e", rx_data_a); end
        n_checks++; if (rx_data_b !== 16'h007E) begin n_fail++; $display("FAIL reset_rx_data_b: got %h want 007e", rx_data_b); end
        n_checks++; if ({rx_valid_a, miso_oe_a, busy_a, frame_err_a, miso_a} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags_a: got %b want 00000", {rx_valid_a, miso_oe_a, busy_a, frame_err_a, miso_a}); end
        n_checks++; if (bit_cnt_a !== 4'd0) begin n_fail++; $display("FAIL reset_bit_cnt: got %0d want 0", bit_cnt_a); end
        rst_n = 1'b1;
        wait_clk(2 * H);
        n_checks++; if ({rx_valid_a, miso_oe_a, busy_a, rx_valid_b, busy_b} !== 5'b0) begin
            n_fail++; $display("FAIL idle_flags: got %b want 00000", {rx_valid_a, miso_oe_a, busy_a, rx_valid_b, busy_b}); end
        n_checks++; if (rx_data_a !== 8'h7E) begin n_fail++; $display("FAIL idle_rx_data_a: got %h want 7e", rx_data_a); end
    endtask

    task automatic test_mode0_basic();
        logic [7:0] seen;
        int lc, v0, e0;
        v0 = nvalid_a; e0 = nerr_a;
        xfer_a(8'hA5, 8'h3C, 8'h3C, 8, 0, seen, lc);
        exp_rx_a = 8'hA5;
        n_checks++; if (rx_data_a !== exp_rx_a) begin n_fail++; $display("FAIL basic_rx_data: got %h want %h", rx_data_a, exp_rx_a); end
        n_checks++; if (seen !== 8'h3C) begin n_fail++; $display("FAIL basic_miso: got %h want 3c", seen); end
        n_checks++; if (nvalid_a - v0 !== 1) begin n_fail++; $display("FAIL basic_pulses: got %0d want 1", nvalid_a - v0); end
        n_checks++; if (valid_cyc_a - lc !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d want 4", valid_cyc_a - lc); end
        n_checks++; if ({busy_a, miso_oe_a} !== 2'b11) begin n_fail++; $display("FAIL basic_busy_oe: got %b want 11", {busy_a, miso_oe_a}); end
        ss_a = 1'b1;
        wait_clk(H);
        n_checks++; if ({busy_a, miso_oe_a} !== 2'b00) begin n_fail++; $display("FAIL basic_release: got %b want 00", {busy_a, miso_oe_a}); end
        n_checks++; if (nerr_a - e0 !== 0) begin n_fail++; $display("FAIL basic_no_err: got %0d want 0", nerr_a - e0); end
    endtask

    task automatic test_mode0_random();
        logic [7:0] m, t, seen;
        int lc, v0;
        for (int k = 0; k < 5; k++) begin
            m = 8'($urandom); t = 8'($urandom);
            v0 = nvalid_a;
            xfer_a(m, t, t, 8, 1, seen, lc);
            exp_rx_a = m;
            n_checks++; if (rx_data_a !== m) begin n_fail++; $display("FAIL rand_rx[%0d]: got %h want %h", k, rx_data_a, m); end
            n_checks++; if (seen !== t) begin n_fail++; $display("FAIL rand_miso[%0d]: got %h want %h", k, seen, t); end
            n_checks++; if (nvalid_a - v0 !== 1) begin n_fail++; $display("FAIL rand_pulses[%0d]: got %0d want 1", k, nvalid_a - v0); end
        end
    endtask

    task automatic test_back_to_back_mode0();
        logic [7:0] m[3], t[4], seen;
        int lc, v0;
        for (int k = 0; k < 3; k++) begin m[k] = 8'($urandom); t[k] = 8'($urandom); end
        t[3] = t[2];
        v0 = nvalid_a;
        for (int k = 0; k < 3; k++) begin
            xfer_a(m[k], t[k], t[k+1], 8, (k == 2) ? 1 : 0, seen, lc);
            exp_rx_a = m[k];
            n_checks++; if (rx_data_a !== m[k]) begin n_fail++; $display("FAIL b2b0_rx[%0d]: got %h want %h", k, rx_data_a, m[k]); end
            n_checks++; if (seen !== t[k]) begin n_fail++; $display("FAIL b2b0_miso[%0d]: got %h want %h", k, seen, t[k]); end
        end
        n_checks++; if (nvalid_a - v0 !== 3) begin n_fail++; $display("FAIL b2b0_pulses: got %0d want 3", nvalid_a - v0); end
    endtask

    task automatic test_back_to_back_mode3();
        logic [15:0] w[4], t[5], seen, got;
        int v0, e0;
        w[0] = 16'h1234; w[1] = 16'hBEEF; w[2] = 16'($urandom); w[3] = 16'($urandom);
        for (int k = 0; k < 4; k++) t[k] = 16'($urandom);
        t[4] = t[3];
        rxq_b.delete();
        v0 = nvalid_b; e0 = nerr_b;
        tx_b = t[0];
        ss_b = 1'b0;
        wait_clk(H);
        for (int k = 0; k < 4; k++) begin
            xfer_b(w[k], t[k+1], seen);
            got = (rxq_b.size() > 0) ? rxq_b.pop_front() : 16'hxxxx;
            n_checks++; if (got !== w[k]) begin n_fail++; $display("FAIL m3_rx[%0d]: got %h want %h", k, got, w[k]); end
            n_checks++; if (seen !== t[k]) begin n_fail++; $display("FAIL m3_miso[%0d]: got %h want %h", k, seen, t[k]); end
        end
        ss_b = 1'b1;
        wait_clk(H);
        n_checks++; if (nvalid_b - v0 !== 4) begin n_fail++; $display("FAIL m3_pulses: got %0d want 4", nvalid_b - v0); end
        n_checks++; if (nerr_b - e0 !== 0) begin n_fail++; $display("FAIL m3_err: got %0d want 0", nerr_b - e0); end
        n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL m3_busy: got %b want 0", busy_b); end
    endtask

    task automatic test_partial_frame();
        logic [7:0] seen;
        int lc, v0, e0;
        v0 = nvalid_a; e0 = nerr_a;
        xfer_a(8'($urandom), 8'h55, 8'h55, 5, 0, seen, lc);
        n_checks++; if (bit_cnt_a !== 4'd5) begin n_fail++; $display("FAIL partial_cnt: got %0d want 5", bit_cnt_a); end
        ss_a = 1'b1;
        wait_clk(H);
        n_checks++; if (nerr_a - e0 !== 1) begin n_fail++; $display("FAIL partial_err: got %0d want 1", nerr_a - e0); end
        n_checks++; if (nvalid_a - v0 !== 0) begin n_fail++; $display("FAIL partial_valid: got %0d want 0", nvalid_a - v0); end
        n_checks++; if (rx_data_a !== exp_rx_a) begin n_fail++; $display("FAIL partial_rx: got %h want %h", rx_data_a, exp_rx_a); end
        n_checks++; if ({busy_a, bit_cnt_a} !== 5'b0) begin n_fail++; $display("FAIL partial_idle: got %b want 00000", {busy_a, bit_cnt_a}); end
    endtask

    task automatic test_release_on_last_sample();
        logic [7:0] m, seen;
        int lc, v0, e0;
        m = 8'($urandom);
        v0 = nvalid_a; e0 = nerr_a;
        xfer_a(m, 8'h00, 8'h00, 8, 2, seen, lc);
        exp_rx_a = m;
        n_checks++; if (nvalid_a - v0 !== 1) begin n_fail++; $display("FAIL simul_valid: got %0d want 1", nvalid_a - v0); end
        n_checks++; if (nerr_a - e0 !== 0) begin n_fail++; $display("FAIL simul_err: got %0d want 0", nerr_a - e0); end
        n_checks++; if (rx_data_a !== m) begin n_fail++; $display("FAIL simul_rx: got %h want %h", rx_data_a, m); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL simul_busy: got %b want 0", busy_a); end
    endtask

    task automatic test_idle_sclk();
        int v0;
        v0 = nvalid_a;
        for (int i = 0; i < 10; i++) begin
            sclk_a = ~sclk_a;
            din_a  = 1'($urandom);
            wait_clk(H);
        end
        sclk_a = 1'b0;
        wait_clk(H);
        n_checks++; if ({busy_a, bit_cnt_a} !== 5'b0) begin n_fail++; $display("FAIL idle_sclk_state: got %b want 00000", {busy_a, bit_cnt_a}); end
        n_checks++; if (nvalid_a - v0 !== 0) begin n_fail++; $display("FAIL idle_sclk_valid: got %0d want 0", nvalid_a - v0); end
    endtask

    task automatic test_reset_abort();
        logic [7:0] seen;
        int lc, v0, e0;
        v0 = nvalid_a; e0 = nerr_a;
        xfer_a(8'hFF, 8'hAA, 8'hAA, 3, 0, seen, lc);
        rst_n = 1'b0;
        ss_a  = 1'b1;
        ss_b  = 1'b1;
        exp_rx_a = 8'h7E;
        wait_clk(4);
        n_checks++; if ({busy_a, bit_cnt_a} !== 5'b0) begin n_fail++; $display("FAIL abort_state: got %b want 00000", {busy_a, bit_cnt_a}); end
        rst_n = 1'b1;
        wait_clk(2 * H);
        n_checks++; if (rx_data_a !== exp_rx_a) begin n_fail++; $display("FAIL abort_rx: got %h want %h", rx_data_a, exp_rx_a); end
        n_checks++; if ((nvalid_a - v0) + (nerr_a - e0) !== 0) begin
            n_fail++; $display("FAIL abort_pulses: got %0d want 0", (nvalid_a - v0) + (nerr_a - e0)); end
        xfer_a(8'h81, 8'h0F, 8'h0F, 8, 1, seen, lc);
        exp_rx_a = 8'h81;
        n_checks++; if (rx_data_a !== exp_rx_a) begin n_fail++; $display("FAIL abort_next_rx: got %h want %h", rx_data_a, exp_rx_a); end
        n_checks++; if (nvalid_a - v0 !== 1) begin n_fail++; $display("FAIL abort_next_valid: got %0d want 1", nvalid_a - v0); end
        n_checks++; if (seen !== 8'h0F) begin n_fail++; $display("FAIL abort_next_miso: got %h want 0f", seen); end
    endtask

    initial begin
        rst_n  = 1'b0;
        sclk_a = 1'b0; ss_a = 1'b1; din_a = 1'b0; tx_a = '0;
        sclk_b = 1'b1; ss_b = 1'b1; din_b = 1'b0; tx_b = '0;
        test_reset();
        test_mode0_basic();
        test_mode0_random();
        test_back_to_back_mode0();
        test_back_to_back_mode3();
        test_partial_frame();
        test_release_on_last_sample();
        test_idle_sclk();
        test_reset_abort();
        n_checks++; if (dbl_a + dbl_b !== 0) begin n_fail++; $display("FAIL valid_consecutive: got %0d want 0", dbl_a + dbl_b); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
